// File: rtl/cmip_cnt_snap_ctrl.sv
// Snapshot/readout controller for a bank of free-running event counters.
// Captures all channels in one cycle (clear or delta mode) and streams them out over valid/ready.
module cmip_cnt_snap_ctrl #(
  parameter int NCH    = 8,
  parameter int WDTH   = 16,
  parameter int PERIOD = 100000,
  parameter int CHW    = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_snap_req,
  input  logic                  i_delta_mode,
  input  logic [NCH*WDTH-1:0]   i_cnt,
  output logic                  o_clr,
  output logic                  o_dat_vld,
  input  logic                  i_dat_rdy,
  output logic [CHW-1:0]        o_dat_ch,
  output logic [WDTH-1:0]       o_dat,
  output logic                  o_dat_last,
  output logic                  o_busy,
  output logic [7:0]            o_miss_cnt,
  input  logic                  i_miss_clr
);

  localparam int            TW      = $clog2(PERIOD + 1);
  localparam logic [TW-1:0] TMR_END = TW'(PERIOD - 1);
  localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPT,
    SEND
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q;
  logic [CHW-1:0]  idx_q;
  logic [7:0]      miss_q;
  logic [WDTH-1:0] snap_q [NCH];
  logic [WDTH-1:0] prev_q [NCH];

  logic tick, trig, drop, beat_xfer, last_beat;

  assign tick      = i_en && (tmr_q == TMR_END);
  assign trig      = tick || i_snap_req;
  assign drop      = trig && (state_q != IDLE);
  assign last_beat = (idx_q == LAST_CH);
  assign beat_xfer = (state_q == SEND) && i_dat_rdy;

  // Periodic timer runs regardless of FSM state; disabling it parks it at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmr_q <= '0;
    end else if (!i_en || tick) begin
      tmr_q <= '0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
      tmr_q <= tmr_q + TW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a value unassigned (no latches).
    state_d    = state_q;
    o_clr      = 1'b0;
    o_dat_vld  = 1'b0;
    o_dat_ch   = '0;
    o_dat      = '0;
    o_dat_last = 1'b0;
    case (state_q)
      IDLE: if (trig) state_d = CAPT;
      CAPT: begin
        o_clr   = ~i_delta_mode;
        state_d = SEND;
      end
      SEND: begin
        o_dat_vld  = 1'b1;
        o_dat_ch   = idx_q;
        o_dat      = snap_q[idx_q];
        o_dat_last = last_beat;
        if (i_dat_rdy && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy = (state_q != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx_q <= '0;
    end else if (state_q == CAPT) begin
      idx_q <= '0;
    end else if (beat_xfer) begin
      idx_q <= last_beat ? '0 : idx_q + CHW'(1);
    end
  end

  // Delta arithmetic wraps modulo 2**WDTH, so a counter rollover between snapshots still yields the true count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: these register arrays are small and must read as zero after reset, so they are reset explicitly.
      for (int k = 0; k < NCH; k++) begin
        snap_q[k] <= '0;
        prev_q[k] <= '0;
      end
    end else if (state_q == CAPT) begin
      for (int k = 0; k < NCH; k++) begin
        if (i_delta_mode) begin
          snap_q[k] <= i_cnt[k*WDTH +: WDTH] - prev_q[k];
          prev_q[k] <= i_cnt[k*WDTH +: WDTH];
        end else begin
          snap_q[k] <= i_cnt[k*WDTH +: WDTH];
          prev_q[k] <= '0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      miss_q <= '0;
    end else if (i_miss_clr) begin
      miss_q <= '0;
    end else if (drop && (miss_q != 8'hFF)) begin
      miss_q <= miss_q + 8'd1;
    end
  end

  assign o_miss_cnt = miss_q;

endmodule
